// File: rtl/serial_add_sequencer.sv
// Operand-pair FIFO and launch/wait/output sequencer for the 8-bit bit-serial adder.
// One pair is in flight at a time; a watchdog turns a silent adder into an error result.
`timescale 1ns/1ps
module serial_add_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic [7:0] add_data_a,
  output logic [7:0] add_data_b,
  output logic       add_start,
  input  logic [7:0] add_out,
  input  logic       add_done,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_err,
  output logic       busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, OUT} state_t;

  pair_t         mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  state_t        state;
  logic [WW-1:0] wd;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign busy     = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{a: in_a, b: in_b};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wd         <= '0;
      add_start  <= 1'b0;
      add_data_a <= '0;
      add_data_b <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      add_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            add_data_a <= mem[rd_ptr[AW-1:0]].a;
            add_data_b <= mem[rd_ptr[AW-1:0]].b;
            rd_ptr     <= rd_ptr + 1'b1;
            add_start  <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // done is only trusted here; a stale done is cleared by start during LAUNCH
          if (add_done) begin
            res_data  <= add_out;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= OUT;
          end else if (wd == WW'(TIMEOUT - 1)) begin
            res_data  <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            state     <= OUT;
          end else begin
            wd <= wd + WW'(1);
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Randomised and directed bench for serial_add_sequencer with a behavioural adder model.
// Expected results are plain sums (or the timeout error) queued in acceptance order.
`timescale 1ns/1ps
module tb_serial_add_sequencer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [7:0] add_data_a;
  logic [7:0] add_data_b;
  logic       add_start;
  logic [7:0] add_out = '0;
  logic       add_done = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_err;
  logic       busy;

  logic        stuck = 1'b0;
  logic        to_mode = 1'b0;
  int unsigned dly = 9;
  int          cnt = 0;
  logic [7:0]  sum = '0;
  int          n_start = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [8:0]  exp_q [$];

  always #5 clk = ~clk;

  serial_add_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_data_a(add_data_a), .add_data_b(add_data_b), .add_start(add_start),
    .add_out(add_out), .add_done(add_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .busy(busy)
  );

  // Adder: start clears done, done rises dly cycles later and then stays high (stale).
  always @(posedge clk) begin
    if (add_start) begin
      add_done <= 1'b0;
      cnt      <= int'(dly);
      sum      <= add_data_a + add_data_b;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1 && !stuck) begin
        add_done <= 1'b1;
        add_out  <= sum;
      end
    end
  end

  always @(posedge clk) if (add_start) n_start <= n_start + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: handshakes seen at negedge complete on the following posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready)
        exp_q.push_back(to_mode ? 9'h100 : {1'b0, 8'(in_a + in_b)});
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) chk("res_unexpected", 32'(exp_q.size()), 32'd1);
        else chk("res", 32'({res_err, res_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(logic [7:0] a, logic [7:0] b);
    int k = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && k < 200) begin
      step();
      k++;
    end
    chk("push_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(string tag);
    int k = 0;
    res_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && k < 500) begin
      step();
      k++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_rst(string tag);
    chk({tag, "_in_ready"},  32'(in_ready),   32'd1);
    chk({tag, "_start"},     32'(add_start),  32'd0);
    chk({tag, "_data_a"},    32'(add_data_a), 32'd0);
    chk({tag, "_data_b"},    32'(add_data_b), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid),  32'd0);
    chk({tag, "_res_data"},  32'(res_data),   32'd0);
    chk({tag, "_res_err"},   32'(res_err),    32'd0);
    chk({tag, "_busy"},      32'(busy),       32'd0);
  endtask

  initial begin
    int lat;
    int s0;
    int k;
    logic [7:0] d0;
    logic seen;

    step(2);
    chk_rst("reset");
    rst = 1'b0;
    step();

    // Single op with latency bound
    res_ready = 1'b1;
    s0 = n_start;
    in_a = 8'h25; in_b = 8'h17; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("single_valid", 32'(res_valid), 32'd1);
    chk("single_data", 32'(res_data), 32'h3c);
    chk("single_lat13", 32'(lat <= 13), 32'd1);
    drain("single_drain");
    chk("single_starts", 32'(n_start - s0), 32'd1);

    // Carry-out dropped
    push(8'hFF, 8'h01);
    push(8'h80, 8'h80);
    push(8'h7F, 8'h01);
    drain("wrap_drain");

    // Stale done from the previous op is still high during LAUNCH
    push(8'h10, 8'h20);
    drain("stale1_drain");
    chk("stale_done_high", 32'(add_done), 32'd1);
    push(8'h01, 8'h01);
    drain("stale2_drain");

    // Burst with backpressure
    res_ready = 1'b0;
    push(8'h01, 8'h02);
    push(8'h03, 8'h04);
    push(8'h10, 8'h20);
    push(8'hAA, 8'h55);
    push(8'hF0, 8'h20);
    in_a = 8'h99; in_b = 8'h99; in_valid = 1'b1;
    chk("burst_full", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b0;
    k = 0;
    while (!res_valid && k < 40) begin
      step();
      k++;
    end
    chk("burst_first_valid", 32'(res_valid), 32'd1);
    chk("burst_first_data", 32'(res_data), 32'h03);
    d0 = res_data;
    s0 = n_start;
    step(20);
    chk("hold_valid", 32'(res_valid), 32'd1);
    chk("hold_data", 32'(res_data), 32'(d0));
    chk("hold_no_start", 32'(n_start - s0), 32'd0);
    drain("burst_drain");

    // Watchdog timeout
    stuck = 1'b1;
    to_mode = 1'b1;
    in_a = 8'h01; in_b = 8'h02; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    k = 0;
    while (!add_start && k < 20) begin
      step();
      k++;
    end
    chk("to_start", 32'(add_start), 32'd1);
    lat = 0;
    while (!res_valid && lat < 60) begin
      step();
      lat++;
    end
    chk("to_dist", 32'(lat), 32'(TIMEOUT + 1));
    chk("to_err", 32'(res_err), 32'd1);
    drain("to_drain");
    stuck = 1'b0;
    to_mode = 1'b0;
    push(8'h05, 8'h06);
    drain("after_to_drain");

    // Reset mid-WAIT with two pairs queued
    push(8'h09, 8'h09);
    push(8'h01, 8'h01);
    push(8'h02, 8'h02);
    step(4);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    exp_q.delete();
    chk_rst("midrst");
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      seen = seen | res_valid | busy;
    end
    chk("midrst_quiet", 32'(seen), 32'd0);
    push(8'h03, 8'h04);
    drain("midrst_drain");

    // Random traffic with random adder delay and backpressure
    for (int i = 0; i < 300; i++) begin
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      res_ready = ($urandom_range(0, 9) < 7);
      dly = $urandom_range(1, 12);
      step();
    end
    in_valid = 1'b0;
    drain("rand_drain");
    chk("final_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
Upstream controller for the 8-bit bit-serial adder. Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. For each pair it drives the adder's parallel operands and one-cycle start pulse, waits for the adder's done, captures its 8-bit result, and presents it on a valid/ready result stream. A watchdog flags an adder that never reports done.

Parameters:
DEPTH, 4, operand FIFO entries; power of two, at least 2.
TIMEOUT, 16, max cycles in WAIT before abort; at least 10.

Ports:
clk  input  1  clock; all logic is on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  FIFO can accept a pair
in_a  input  8  operand A
in_b  input  8  operand B
add_data_a  output  8  to adder data_a; registered
add_data_b  output  8  to adder data_b; registered
add_start  output  1  to adder start; one-cycle pulse
add_out  input  8  from adder out
add_done  input  1  from adder done
res_valid  output  1  result valid
res_ready  input  1  result consumer ready
res_data  output  8  sum mod 256
res_err  output  1  result is a timeout abort
busy  output  1  FSM not in IDLE, or FIFO not empty

Behaviour:
- Reset, synchronous on rst=1 at a clk edge:
  - FSM goes to IDLE; FIFO is emptied; watchdog is cleared.
  - in_ready=1, add_start=0, add_data_a=0, add_data_b=0, res_valid=0, res_data=0, res_err=0, busy=0.
  - Reset has priority over every other event, including mid-WAIT and mid-OUT.
  - An in-flight adder operation is abandoned; the next LAUNCH restarts the adder.
- FIFO:
  - Push when in_valid && in_ready; in_ready = !full.
  - No bypass: a pop and a push in the same cycle are legal, but a push into a full FIFO is never accepted, even if a pop happens that cycle.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally; order is strictly FIFO.
- FSM, one transition per cycle:
  - IDLE: if FIFO is non-empty, pop the head, load add_data_a/add_data_b, go to LAUNCH.
  - LAUNCH: add_start=1 for exactly this cycle; operands stay stable; clear the watchdog; go to WAIT.
  - WAIT:
    - add_start=0 and the watchdog increments each cycle.
    - add_done is sampled only in WAIT. A stale done left over from the previous operation is ignored because the adder's start clears it during LAUNCH.
    - If add_done=1: res_data<=add_out, res_err<=0, go to OUT.
    - Else if the watchdog reaches TIMEOUT-1: res_data<=0, res_err<=1, go to OUT.
    - If done arrives in the same cycle as the timeout, done wins.
  - OUT:
    - res_valid=1; res_data and res_err are held stable until res_ready=1.
    - On res_valid && res_ready: res_valid<=0, then go to IDLE.
    - No new launch happens while in OUT.
- Operands stay held in add_data_a/b until the next IDLE pop.
- Latency:
  - Pair accepted at edge N: IDLE pops at N+1, LAUNCH at N+2, WAIT from N+3.
  - Nominal adder done arrives about 9 cycles after start falls.
  - res_valid rises the cycle after done is sampled.
  - Nominal in_valid to res_valid is 13 cycles with an empty FIFO and res_ready=1.
- Arithmetic: the result is 8 bits; the carry-out is dropped (0xFF+0x01 gives 0x00, res_err=0).
- Throughput: one result per LAUNCH+WAIT+OUT+IDLE loop. The FIFO absorbs bursts of up to DEPTH pairs.

Test Plan:
- Single op: push 0x25/0x17 with the real adder attached -> one add_start pulse, then res_valid with res_data=0x3C, res_err=0; response within 13 cycles.
- Wrap: 0xFF/0x01 -> res_data=0x00; then 0x80/0x80 -> 0x00; then 0x7F/0x01 -> 0x80.
- Burst and backpressure: push 5 pairs back-to-back with res_ready=0.
  - 5 pairs accepted: the first pops immediately, the next 4 fill the FIFO (DEPTH=4); in_ready=0 on the 6th attempt.
  - The first result is held stable with no second add_start until res_ready=1.
  - All results arrive in order: (1,2)->3, (3,4)->7, (0x10,0x20)->0x30, (0xAA,0x55)->0xFF, (0xF0,0x20)->0x10.
- Timeout: tie add_done=0, push 0x01/0x02 -> after TIMEOUT=16 WAIT cycles, res_valid=1, res_err=1, res_data=0x00; the next op proceeds normally.
- Stale done: hold add_done=1 into LAUNCH from the previous op -> no early capture; the sequencer captures only on a done seen in WAIT.
- Reset mid-WAIT with 2 pairs queued: assert rst for 1 cycle -> next cycle all outputs at reset values, FIFO empty, busy=0, no res_valid; a new push of 0x03/0x04 gives 0x07.
